// File: rtl/sc_fifo_pkg.sv
// Shared defaults for the counter-fed FIFO block.
//   DEF_WIDTH        - default data width of counter and FIFO words
//   DEF_DEPTH        - default FIFO depth in words (power of two, >= 4)
//   DEF_RST_BUSY_CYC - default clocks the reset-busy flags stay high after release
//   PTR_W            - pointer width for the default depth
package sc_fifo_pkg;
    localparam int DEF_WIDTH        = 32;
    localparam int DEF_DEPTH        = 16;
    localparam int DEF_RST_BUSY_CYC = 2;
    localparam int PTR_W            = $clog2(DEF_DEPTH);
endpackage

// File: rtl/count_gen.sv
// Free-running up-counter used as the FIFO test-pattern source.
//   clk         - clock, rising edge
//   reset_n     - asynchronous active-low reset, clears the count
//   start_count - 1 = increment every clock, 0 = hold
//   count       - current counter value, wraps all-ones -> 0
module count_gen
    import sc_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_count,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (start_count) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/sc_fifo_counter.sv
// Single-clock FIFO whose write data is an internal free-running counter.
//   clk          - clock, rising edge
//   reset_n      - asynchronous assert, active-low reset
//   start_count  - 1 = counter increments every clock
//   wr_en        - write request, stores the current count
//   rd_en        - read request
//   count        - current counter value (FIFO write data)
//   dout         - registered read data, one clock after an accepted read
//   full         - FIFO holds DEPTH words, or the block is still coming out of reset
//   empty        - FIFO holds no words
//   wr_rst_busy  - write side busy after reset, writes ignored
//   rd_rst_busy  - read side busy after reset, reads ignored
//   overflow     - one-clock pulse after a write dropped because the FIFO was full
//   underflow    - one-clock pulse after a read dropped because the FIFO was empty
module sc_fifo_counter
    import sc_fifo_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int RST_BUSY_CYC = DEF_RST_BUSY_CYC   // must be >= 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_count,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             wr_rst_busy,
    output logic             rd_rst_busy,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int BUSY_W   = (RST_BUSY_CYC < 2) ? 1 : $clog2(RST_BUSY_CYC + 1);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wptr_reg, rptr_reg;
    logic [PTR_BITS:0]   occ_reg, occ_next;
    logic [BUSY_W-1:0]   busy_cnt_reg, busy_cnt_next;
    logic                busy_reg, busy_next;
    logic                full_reg, empty_reg;
    logic                overflow_reg, underflow_reg;
    logic [WIDTH-1:0]    dout_reg;
    logic                wr_accept, rd_accept;

    count_gen #(.WIDTH(WIDTH)) u_count_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_count (start_count),
        .count       (count)
    );

    // full_reg is forced high while busy, so it alone would block writes; the
    // explicit busy term keeps the intent obvious and covers reads too.
    assign wr_accept = wr_en & ~full_reg  & ~busy_reg;
    assign rd_accept = rd_en & ~empty_reg & ~busy_reg;

    always_comb begin
        occ_next = occ_reg;
        case ({wr_accept, rd_accept})
            2'b10:   occ_next = occ_reg + (PTR_BITS+1)'(1);
            2'b01:   occ_next = occ_reg - (PTR_BITS+1)'(1);
            default: occ_next = occ_reg;
        endcase
    end

    // Busy window: counts rising edges after release, drops on the last one.
    always_comb begin
        busy_cnt_next = busy_cnt_reg;
        busy_next     = busy_reg;
        if (busy_reg) begin
            busy_cnt_next = busy_cnt_reg + BUSY_W'(1);
            if (busy_cnt_next == BUSY_W'(RST_BUSY_CYC)) begin
                busy_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            occ_reg       <= '0;
            busy_cnt_reg  <= '0;
            busy_reg      <= 1'b1;
            full_reg      <= 1'b1;
            empty_reg     <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            dout_reg      <= '0;
        end else begin
            occ_reg       <= occ_next;
            busy_cnt_reg  <= busy_cnt_next;
            busy_reg      <= busy_next;
            // full tracks occupancy only once the busy window has closed
            full_reg      <= busy_next | (occ_next == (PTR_BITS+1)'(DEPTH));
            empty_reg     <= (occ_next == '0);
            overflow_reg  <= wr_en & full_reg  & ~busy_reg;
            underflow_reg <= rd_en & empty_reg & ~busy_reg;
            if (wr_accept) begin
                wptr_reg <= wptr_reg + PTR_BITS'(1);
            end
            if (rd_accept) begin
                rptr_reg <= rptr_reg + PTR_BITS'(1);
                dout_reg <= mem[rptr_reg];
            end
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr_reg] <= count;
        end
    end

    assign dout        = dout_reg;
    assign full        = full_reg;
    assign empty       = empty_reg;
    assign wr_rst_busy = busy_reg;
    assign rd_rst_busy = busy_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;

endmodule

// File: tb/tb_sc_fifo_counter.sv
module tb_sc_fifo_counter;
    localparam int D    = 16;
    localparam int BUSY = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start_count = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] count, dout;
    logic        full, empty, wr_rst_busy, rd_rst_busy, overflow, underflow;

    // narrow instance used to reach the counter wrap quickly
    logic [3:0]  s_count, s_dout;
    logic        s_full, s_empty, s_wbusy, s_rbusy, s_ovf, s_udf;

    always #5 clk = ~clk;

    sc_fifo_counter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_count (start_count),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .count       (count),
        .dout        (dout),
        .full        (full),
        .empty       (empty),
        .wr_rst_busy (wr_rst_busy),
        .rd_rst_busy (rd_rst_busy),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    sc_fifo_counter #(.WIDTH(4), .DEPTH(4), .RST_BUSY_CYC(2)) dut_small (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_count (start_count),
        .wr_en       (1'b0),
        .rd_en       (1'b0),
        .count       (s_count),
        .dout        (s_dout),
        .full        (s_full),
        .empty       (s_empty),
        .wr_rst_busy (s_wbusy),
        .rd_rst_busy (s_rbusy),
        .overflow    (s_ovf),
        .underflow   (s_udf)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] q[$];
    logic [31:0] m_count, m_dout;
    int          m_busy_left;
    bit          m_full, m_empty, m_ovf, m_udf;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_count     = '0;
        m_dout      = '0;
        m_busy_left = BUSY;
        m_full      = 1'b1;
        m_empty     = 1'b1;
        m_ovf       = 1'b0;
        m_udf       = 1'b0;
    endtask

    task automatic model_edge(input bit w, input bit r, input bit s);
        bit busy, wacc, racc;
        if (!reset_n) begin
            model_reset();
        end else begin
            busy  = (m_busy_left > 0);
            wacc  = w && !m_full  && !busy;
            racc  = r && !m_empty && !busy;
            m_ovf = w && m_full  && !busy;
            m_udf = r && m_empty && !busy;
            if (racc) m_dout = q.pop_front();
            if (wacc) q.push_back(m_count);
            if (s) m_count = m_count + 32'd1;
            if (busy) m_busy_left--;
            m_full  = (m_busy_left > 0) || (q.size() == D);
            m_empty = (q.size() == 0);
        end
    endtask

    // one compare process, checks every cycle on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("count", count, m_count);
            check("dout", dout, m_dout);
            check("full", {31'b0, full}, {31'b0, m_full});
            check("empty", {31'b0, empty}, {31'b0, m_empty});
            check("wr_rst_busy", {31'b0, wr_rst_busy}, {31'b0, (m_busy_left > 0)});
            check("rd_rst_busy", {31'b0, rd_rst_busy}, {31'b0, (m_busy_left > 0)});
            check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
            check("underflow", {31'b0, underflow}, {31'b0, m_udf});
            check("small_count", {28'b0, s_count}, {28'b0, m_count[3:0]});
        end
    end

    task automatic tick(input bit w, input bit r, input bit s);
        wr_en = w;
        rd_en = r;
        start_count = s;
        @(posedge clk);
        model_edge(w, r, s);
        #1;
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_count", count, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_full", {31'b0, full}, 32'd1);
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_busy", {31'b0, wr_rst_busy}, 32'd1);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
    endtask

    initial begin
        logic [31:0] prev, saved;
        #1;
        assert_reset();
        chk_en = 1'b1;
        repeat (3) tick(1, 0, 1);
        reset_n = 1'b1;

        // 1: busy for two edges, then 16 writes of 2..17
        tick(1, 0, 1);
        check("t1_busy_edge1", {31'b0, wr_rst_busy}, 32'd1);
        tick(1, 0, 1);
        check("t1_busy_edge2", {31'b0, wr_rst_busy}, 32'd0);
        check("t1_full_after_busy", {31'b0, full}, 32'd0);
        repeat (16) tick(1, 0, 1);
        check("t1_full", {31'b0, full}, 32'd1);
        check("t1_count", count, 32'd18);
        check("t1_model_first", q[0], 32'd2);
        check("t1_model_last", q[15], 32'd17);

        // 2: writes while full overflow every clock
        repeat (3) begin
            tick(1, 0, 1);
            check("t2_overflow", {31'b0, overflow}, 32'd1);
        end
        check("t2_model_size", q.size(), 32'd16);

        // 3: drain, data 2..17, then underflow
        for (int i = 0; i < 16; i++) begin
            tick(0, 1, 1);
            check("t3_dout", dout, 32'd2 + 32'(i));
        end
        check("t3_empty", {31'b0, empty}, 32'd1);
        tick(0, 1, 1);
        check("t3_underflow", {31'b0, underflow}, 32'd1);
        check("t3_dout_hold", dout, 32'd17);
        tick(0, 0, 1);
        check("t3_underflow_clr", {31'b0, underflow}, 32'd0);

        // 4: half full, simultaneous read/write
        repeat (8) tick(1, 0, 1);
        for (int i = 0; i < 20; i++) begin
            prev = m_dout;
            tick(1, 1, 1);
            check("t4_dout_incr", {31'b0, (dout > prev)}, 32'd1);
            check("t4_occupancy", q.size(), 32'd8);
        end

        // 5: counter hold, then wrap on the narrow instance
        saved = m_count;
        repeat (3) tick(0, 0, 0);
        check("t5_hold", count, saved);
        for (int i = 0; i < 16 && m_count[3:0] != 4'hF; i++) tick(0, 0, 1);
        check("t5_small_ones", {28'b0, s_count}, 32'd15);
        tick(0, 0, 1);
        check("t5_small_wrap", {28'b0, s_count}, 32'd0);

        // 6: reset with 5 words stored
        assert_reset();
        repeat (2) tick(0, 0, 1);
        reset_n = 1'b1;
        repeat (2) tick(0, 0, 1);
        repeat (6) tick(1, 0, 1);
        tick(0, 1, 1);
        check("t6_dout", dout, 32'd2);
        check("t6_model_size", q.size(), 32'd5);
        assert_reset();
        repeat (2) tick(0, 0, 1);
        reset_n = 1'b1;
        repeat (4) tick(0, 0, 0);
        check("t6_empty_after", {31'b0, empty}, 32'd1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
